// File: rtl/multdiv_seq_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: start/abort/restart
// handling, per-cycle datapath strobes and a one-cycle done pulse.
module multdiv_seq_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ITERS      = 32,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned RESTART_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             init_cycle,
    output logic             sec_cycle,
    output logic             iter_en,
    output logic             last_iter,
    output logic             done,
    output logic             exception,
    output logic             op_is_div,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FINISH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS);
    localparam logic [CNT_W-1:0] CNT_FIN  = CNT_W'(ITERS + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_count;
    logic             w_next_op;
    logic             w_next_exc;
    logic             w_accept;
    logic             w_div_zero;

    assign w_div_zero = (divisor == '0);
    // A start is taken in IDLE, or anywhere when restarts are enabled; abort always wins.
    assign w_accept   = start && !abort && ((r_state == ST_IDLE) || (RESTART_EN != 0));

    // Next-state, count, latched op and exception flag
    always_comb begin
        w_next_state = r_state;
        w_next_count = count;
        w_next_op    = op_is_div;
        w_next_exc   = exception;
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
            w_next_count = CNT_ZERO;
            w_next_exc   = 1'b0;
        end else if (w_accept) begin
            w_next_op    = op_div;
            w_next_count = CNT_ZERO;
            if (op_div && w_div_zero) begin
                w_next_state = ST_FINISH;
                w_next_exc   = 1'b1;
            end else begin
                w_next_state = ST_INIT;
                w_next_exc   = 1'b0;
            end
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_next_state = ST_RUN;
                    w_next_count = CNT_ONE;
                end
                ST_RUN: begin
                    if (count == CNT_LAST) begin
                        w_next_state = ST_FINISH;
                        w_next_count = CNT_FIN;
                    end else begin
                        w_next_count = count + CNT_ONE;
                    end
                end
                ST_FINISH: begin
                    w_next_state = ST_IDLE;
                    w_next_count = CNT_ZERO;
                    w_next_exc   = 1'b0;
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_count = CNT_ZERO;
                end
            endcase
        end
    end

    // State plus registered output decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            count      <= CNT_ZERO;
            op_is_div  <= 1'b0;
            exception  <= 1'b0;
            busy       <= 1'b0;
            init_cycle <= 1'b0;
            sec_cycle  <= 1'b0;
            iter_en    <= 1'b0;
            last_iter  <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            count      <= w_next_count;
            op_is_div  <= w_next_op;
            exception  <= w_next_exc;
            busy       <= (w_next_state != ST_IDLE);
            init_cycle <= (w_next_state == ST_INIT);
            sec_cycle  <= (w_next_state == ST_RUN) && (w_next_count == CNT_ONE);
            iter_en    <= (w_next_state == ST_RUN);
            last_iter  <= (w_next_state == ST_RUN) && (w_next_count == CNT_LAST);
            done       <= (w_next_state == ST_FINISH);
        end
    end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Scoreboard bench: three sequencer instances (restart off/on, short iteration count).
module tb_multdiv_seq_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         op_div = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] divisor = '0;
    logic         start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic busy_a, init_a, sec_a, iter_a, last_a, done_a, exc_a, opd_a;
    logic busy_b, init_b, sec_b, iter_b, last_b, done_b, exc_b, opd_b;
    logic busy_c, init_c, sec_c, iter_c, last_c, done_c, exc_c, opd_c;
    logic [5:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;

    always #5 clk = ~clk;

    multdiv_seq_ctrl #(.WIDTH(W), .ITERS(32), .CNT_W(6), .RESTART_EN(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .op_div(op_div), .divisor(divisor),
        .abort(abort), .busy(busy_a), .init_cycle(init_a), .sec_cycle(sec_a),
        .iter_en(iter_a), .last_iter(last_a), .done(done_a), .exception(exc_a),
        .op_is_div(opd_a), .count(cnt_a));

    multdiv_seq_ctrl #(.WIDTH(W), .ITERS(32), .CNT_W(6), .RESTART_EN(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .op_div(op_div), .divisor(divisor),
        .abort(abort), .busy(busy_b), .init_cycle(init_b), .sec_cycle(sec_b),
        .iter_en(iter_b), .last_iter(last_b), .done(done_b), .exception(exc_b),
        .op_is_div(opd_b), .count(cnt_b));

    multdiv_seq_ctrl #(.WIDTH(W), .ITERS(4), .CNT_W(3), .RESTART_EN(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .op_div(op_div), .divisor(divisor),
        .abort(abort), .busy(busy_c), .init_cycle(init_c), .sec_cycle(sec_c),
        .iter_en(iter_c), .last_iter(last_c), .done(done_c), .exception(exc_c),
        .op_is_div(opd_c), .count(cnt_c));

    typedef struct {
        int id;
        int cyc;
        int exc;
        int opd;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic int exc_of(input int d);
        case (d)
            0: return int'(exc_a);
            1: return int'(exc_b);
            default: return int'(exc_c);
        endcase
    endfunction

    function automatic int opd_of(input int d);
        case (d)
            0: return int'(opd_a);
            1: return int'(opd_b);
            default: return int'(opd_c);
        endcase
    endfunction

    function automatic int cnt_of(input int d);
        case (d)
            0: return int'(cnt_a);
            1: return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        logic [2:0] dv;
        exp_t       e;
        dv = {done_c, done_b, done_a};
        for (int d = 0; d < 3; d++) begin
            if (dv[d]) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_done_dut%0d", d), 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_dut_id", d, e.id);
                    check("done_cycle", cyc, e.cyc);
                    check("done_exception", exc_of(d), e.exc);
                    check("done_op_is_div", opd_of(d), e.opd);
                    check("done_count", cnt_of(d), e.cnt);
                end
            end
        end
    end

    task automatic push(input int id, input int c, input int exc, input int opd, input int cnt);
        exp_t e;
        e.id = id; e.cyc = c; e.exc = exc; e.opd = opd; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // One-cycle start pulse; d returns the cycle in which start was presented
    task automatic pulse(input int id, input logic od, input logic [W-1:0] dv, output int d);
        @(negedge clk);
        op_div = od;
        divisor = dv;
        case (id)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        d = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_cnt(input int id, input int tgt);
        int n;
        n = 0;
        while (cnt_of(id) != tgt && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("wait_count_dut%0d", id), cnt_of(id), tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int d;
        int n_iter;

        // Reset state
        @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_count", int'(cnt_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_exc", int'(exc_a), 0);
        check("rst_opd", int'(opd_a), 0);
        check("rst_busy_c", int'(busy_c), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Multiply: full strobe sequence, cycle by cycle
        @(negedge clk);
        op_div = 1'b0;
        start_a = 1'b1;
        d = cyc;
        push(0, d + 34, 0, 0, 33);
        n_iter = 0;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            check($sformatf("mul_busy_k%0d", k), int'(busy_a), 1);
            check($sformatf("mul_count_k%0d", k), int'(cnt_a), k);
            check($sformatf("mul_init_k%0d", k), int'(init_a), (k == 0) ? 1 : 0);
            check($sformatf("mul_sec_k%0d", k), int'(sec_a), (k == 1) ? 1 : 0);
            check($sformatf("mul_last_k%0d", k), int'(last_a), (k == 32) ? 1 : 0);
            check($sformatf("mul_iter_k%0d", k), int'(iter_a), (k >= 1 && k <= 32) ? 1 : 0);
            n_iter += int'(iter_a);
        end
        check("mul_iter_total", n_iter, 32);
        @(negedge clk);
        check("mul_idle_busy", int'(busy_a), 0);
        check("mul_idle_count", int'(cnt_a), 0);

        // Divide by zero: done with exception the cycle after start
        pulse(0, 1'b1, '0, d);
        push(0, d + 1, 1, 1, 0);
        check("dz_busy", int'(busy_a), 1);
        check("dz_init", int'(init_a), 0);
        check("dz_iter", int'(iter_a), 0);
        check("dz_exc", int'(exc_a), 1);
        @(negedge clk);
        check("dz_after_busy", int'(busy_a), 0);
        check("dz_after_exc", int'(exc_a), 0);

        // Normal divide
        pulse(0, 1'b1, W'(7), d);
        push(0, d + 34, 0, 1, 33);
        repeat (36) @(negedge clk);

        // Abort at count 10: no done pulse
        pulse(0, 1'b0, W'(1), d);
        wait_cnt(0, 10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy_a), 0);
        check("abort_count", int'(cnt_a), 0);
        repeat (40) @(negedge clk);

        // Start while running, restart disabled: ignored
        pulse(0, 1'b0, W'(1), d);
        push(0, d + 34, 0, 0, 33);
        wait_cnt(0, 5);
        op_div = 1'b1;
        divisor = '0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("norestart_count", int'(cnt_a), 6);
        check("norestart_init", int'(init_a), 0);
        check("norestart_opd", int'(opd_a), 0);
        repeat (32) @(negedge clk);

        // Start while running, restart enabled: new op from INIT
        pulse(1, 1'b0, W'(1), d);
        wait_cnt(1, 5);
        op_div = 1'b1;
        divisor = W'(3);
        start_b = 1'b1;
        push(1, cyc + 34, 0, 1, 33);
        @(negedge clk);
        start_b = 1'b0;
        check("restart_init", int'(init_b), 1);
        check("restart_count", int'(cnt_b), 0);
        check("restart_opd", int'(opd_b), 1);
        repeat (36) @(negedge clk);

        // Restart during FINISH: done kept, then div-by-zero completion
        pulse(1, 1'b0, W'(1), d);
        push(1, d + 34, 0, 0, 33);
        repeat (33) @(negedge clk);
        check("fin_done_b", int'(done_b), 1);
        op_div = 1'b1;
        divisor = '0;
        start_b = 1'b1;
        push(1, cyc + 1, 1, 1, 0);
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        check("fin_after_busy", int'(busy_b), 0);
        check("fin_after_exc", int'(exc_b), 0);

        // Asynchronous reset mid-operation, then a fresh divide
        pulse(0, 1'b1, W'(5), d);
        wait_cnt(0, 20);
        check("pre_rst_opd", int'(opd_a), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", int'(busy_a), 0);
        check("async_count", int'(cnt_a), 0);
        check("async_iter", int'(iter_a), 0);
        check("async_opd", int'(opd_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(0, 1'b1, W'(9), d);
        push(0, d + 34, 0, 1, 33);
        check("post_rst_init", int'(init_a), 1);
        repeat (36) @(negedge clk);

        // Short sequencer, start held high: one idle cycle between operations
        @(negedge clk);
        op_div = 1'b0;
        divisor = W'(1);
        start_c = 1'b1;
        d = cyc;
        push(2, d + 6, 0, 0, 5);
        push(2, d + 13, 0, 0, 5);
        push(2, d + 20, 0, 0, 5);
        repeat (7) @(negedge clk);
        check("b2b_idle1", int'(busy_c), 0);
        repeat (7) @(negedge clk);
        check("b2b_idle2", int'(busy_c), 0);
        repeat (6) @(negedge clk);
        start_c = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_stopped", int'(busy_c), 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
